router_sync_n: RTL and testbench

ROUTER_SYNC_N -- requirements
Module: router_sync_n

---
 rtl/router_pkg.sv | 14 +
 rtl/router_sync_timer.sv | 49 ++++
 rtl/router_sync_n.sv | 95 +++++++++
 tb/tb_router_sync_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants used by the sync block, FIFOs and FSM.
// Also holds the address range helper used when ROUTER_SYNC_ADDR_ERR_EN is defined.
package router_pkg;

  localparam int ROUTER_NUM_CH  = 3;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_TIMEOUT = 30;

  // True when the header address selects an existing channel.
  function automatic logic addr_in_range(input logic [31:0] addr, input int num_ch);
    return (addr < 32'(num_ch));
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges with valid data that the consumer does not read.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic read,
  output logic soft_reset
);

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // A read on the terminal count wins over the flush pulse.
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!vld || read) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the header address, steers FIFO write enable
// and full flag, and flushes stalled channels. Option: ROUTER_SYNC_ADDR_ERR_EN.
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_CH  = ROUTER_NUM_CH,
  parameter int ADDR_W  = ROUTER_ADDR_W,
  parameter int TIMEOUT = ROUTER_TIMEOUT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] vld_out,
`ifdef ROUTER_SYNC_ADDR_ERR_EN
  output logic              addr_err,
`endif
  output logic [NUM_CH-1:0] soft_reset
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    if (detect_add) begin
      addr_d = data_in;
    end else begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // An out-of-range address matches no channel, so everything stays 0.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_q == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end else begin
        write_enb[i] = 1'b0;
      end
    end
  end

  assign vld_out = ~empty;

`ifdef ROUTER_SYNC_ADDR_ERR_EN
  logic addr_err_q, addr_err_d;

  always_comb begin
    if (detect_add) begin
      addr_err_d = ~addr_in_range(32'(data_in), NUM_CH);
    end else begin
      addr_err_d = addr_err_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .TIMEOUT(TIMEOUT)
    ) u_timer (
      .clock     (clock),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .read      (read_enb[g]),
      .soft_reset(soft_reset[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// Directed bench for router_sync_n: default build plus a NUM_CH=4, TIMEOUT=8 instance.
// Checks addr_err too when ROUTER_SYNC_ADDR_ERR_EN is defined.
module tb_router_sync_n;

  logic       clock = 1'b0;
  logic       resetn;
  logic       detect_add, write_enb_reg, fifo_full;
  logic [1:0] data_in;
  logic [2:0] full, empty, read_enb, write_enb, vld_out, soft_reset;
  logic       addr_err;

  logic       d4_detect_add, d4_write_enb_reg, d4_fifo_full;
  logic [1:0] d4_data_in;
  logic [3:0] d4_full, d4_empty, d4_read_enb, d4_write_enb, d4_vld_out, d4_soft_reset;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  router_sync_n u_dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .full         (full),
    .empty        (empty),
    .read_enb     (read_enb),
    .fifo_full    (fifo_full),
    .write_enb    (write_enb),
    .vld_out      (vld_out),
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    .addr_err     (addr_err),
`endif
    .soft_reset   (soft_reset)
  );

`ifndef ROUTER_SYNC_ADDR_ERR_EN
  assign addr_err = 1'b0;
`endif

  router_sync_n #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(8)) u_dut4 (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (d4_detect_add),
    .data_in      (d4_data_in),
    .write_enb_reg(d4_write_enb_reg),
    .full         (d4_full),
    .empty        (d4_empty),
    .read_enb     (d4_read_enb),
    .fifo_full    (d4_fifo_full),
    .write_enb    (d4_write_enb),
    .vld_out      (d4_vld_out),
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    .addr_err     (),
`endif
    .soft_reset   (d4_soft_reset)
  );

  typedef struct packed {
    logic       da;
    logic [1:0] di;
    logic       wer;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
    logic       exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn        = 1'b0;
    detect_add    = 1'b0;
    data_in       = 2'd0;
    write_enb_reg = 1'b0;
    full          = 3'b000;
    empty         = 3'b111;
    read_enb      = 3'b000;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Hold a stall pattern for n_edges edges; pulses expected only at p1/p2.
  task automatic run_stall(input string tag, input logic [2:0] emp, input int rd_edge,
                           input logic [2:0] rd_mask, input int p1, input int p2,
                           input int n_edges, input logic [2:0] mask);
    do_reset();
    empty = emp;
    for (int e = 1; e <= n_edges; e++) begin
      read_enb = (e == rd_edge) ? rd_mask : 3'b000;
      @(posedge clock);
      #1;
      check($sformatf("%s edge %0d soft_reset", tag, e), 32'(soft_reset),
            (e == p1 || e == p2) ? 32'(mask) : 32'd0);
      @(negedge clock);
    end
    read_enb = 3'b000;
  endtask

  initial begin
    resetn = 1'b1;
    d4_detect_add = 1'b0; d4_data_in = 2'd0; d4_write_enb_reg = 1'b0;
    d4_full = 4'b0000; d4_empty = 4'b1111; d4_read_enb = 4'b0000;

    //        da    di    wer   full    empty   we      ff    vld     err
    tbl[0] = {1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b001, 1'b0, 3'b000, 1'b0};
    tbl[1] = {1'b1, 2'd1, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0};
    tbl[2] = {1'b0, 2'd0, 1'b1, 3'b010, 3'b101, 3'b010, 1'b1, 3'b010, 1'b0};
    tbl[3] = {1'b0, 2'd0, 1'b0, 3'b101, 3'b011, 3'b000, 1'b0, 3'b100, 1'b0};
    tbl[4] = {1'b1, 2'd3, 1'b1, 3'b111, 3'b000, 3'b010, 1'b1, 3'b111, 1'b0};
    tbl[5] = {1'b0, 2'd0, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1};
    tbl[6] = {1'b1, 2'd2, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b1};
    tbl[7] = {1'b0, 2'd0, 1'b1, 3'b100, 3'b110, 3'b100, 1'b1, 3'b001, 1'b0};
    tbl[8] = {1'b1, 2'd0, 1'b0, 3'b011, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0};
    tbl[9] = {1'b0, 2'd0, 1'b1, 3'b001, 3'b111, 3'b001, 1'b1, 3'b000, 1'b0};

    // Outputs while reset is held: addr reads as 0.
    resetn = 1'b0;
    detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b1;
    full = 3'b001; empty = 3'b111; read_enb = 3'b000;
    #2;
    check("rst write_enb", 32'(write_enb), 32'h1);
    check("rst fifo_full", 32'(fifo_full), 32'h1);
    check("rst soft_reset", 32'(soft_reset), 32'h0);
    check("rst vld_out", 32'(vld_out), 32'h0);
    check("rst addr_err", 32'(addr_err), 32'h0);
    check("rst d4 soft_reset", 32'(d4_soft_reset), 32'h0);
    @(negedge clock);
    resetn = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      detect_add    = tbl[k].da;
      data_in       = tbl[k].di;
      write_enb_reg = tbl[k].wer;
      full          = tbl[k].full;
      empty         = tbl[k].empty;
      #1;
      check($sformatf("vec%0d write_enb", k), 32'(write_enb), 32'(tbl[k].exp_we));
      check($sformatf("vec%0d fifo_full", k), 32'(fifo_full), 32'(tbl[k].exp_ff));
      check($sformatf("vec%0d vld_out", k), 32'(vld_out), 32'(tbl[k].exp_vld));
      check($sformatf("vec%0d soft_reset", k), 32'(soft_reset), 32'h0);
`ifdef ROUTER_SYNC_ADDR_ERR_EN
      check($sformatf("vec%0d addr_err", k), 32'(addr_err), 32'(tbl[k].exp_err));
`endif
    end

    run_stall("stall", 3'b101, 0, 3'b000, 30, 60, 65, 3'b010);
    run_stall("read29", 3'b101, 29, 3'b010, 59, 0, 65, 3'b010);
    run_stall("read30", 3'b101, 30, 3'b010, 60, 0, 65, 3'b010);

    // Reset in the middle of a stall throws away the count.
    do_reset();
    empty = 3'b110;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("mid pre edge %0d", e), 32'(soft_reset), 32'h0);
    end
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("mid in reset soft_reset", 32'(soft_reset), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("mid post edge %0d", e), 32'(soft_reset), (e == 30) ? 32'h1 : 32'h0);
    end

    // Four-channel instance with a short timeout.
    do_reset();
    d4_detect_add = 1'b1; d4_data_in = 2'd3; d4_write_enb_reg = 1'b1; d4_full = 4'b1000;
    @(negedge clock);
    d4_detect_add = 1'b0; d4_empty = 4'b0111;
    #1;
    check("d4 write_enb", 32'(d4_write_enb), 32'h8);
    check("d4 fifo_full", 32'(d4_fifo_full), 32'h1);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("d4 edge %0d soft_reset", e), 32'(d4_soft_reset), (e == 8) ? 32'h8 : 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
